// File: rtl/axi_pkg.sv
// AXI response/burst encodings and channel FSM states shared by the memory slave.
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Only full-width FIXED and INCR bursts touch the array.
    function automatic logic burstLegal(input logic [2:0] size,
                                        input logic [1:0] burst,
                                        input logic [2:0] fullSize);
        return (size == fullSize) &&
               ((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word array with a byte-enabled synchronous write port and a combinational read port.
module axi_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clk_i,
    input  logic                         wrEn_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] wrIdx_i,
    input  logic [DATA_WIDTH-1:0]        wrData_i,
    input  logic [DATA_WIDTH/8-1:0]      wrStrb_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] rdIdx_i,
    output logic [DATA_WIDTH-1:0]        rdData_o
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wrStrb_i[b]) begin
                    mem[wrIdx_i][8*b +: 8] <= wrData_i[8*b +: 8];
                end
            end
        end
    end

    // Reading before the edge gives old data on a same-cycle write to the same word.
    assign rdData_o = mem[rdIdx_i];

endmodule

// File: rtl/s_axi_mem.sv
// AXI4 full slave scratch memory: independent write and read burst FSMs,
// one beat per cycle, SLVERR for unsupported bursts or wlast mismatches.
module s_axi_mem
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int         ADDR_LSB  = $clog2(DATA_WIDTH / 8);
    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [2:0] FULL_SIZE = 3'(ADDR_LSB);

    w_state_e              wState_q, wState_d;
    logic [ID_WIDTH-1:0]   wId_q, wId_d;
    logic [IDX_W-1:0]      wIdx_q, wIdx_d;
    logic [7:0]            wLen_q, wLen_d, wCnt_q, wCnt_d;
    logic                  wIncr_q, wIncr_d, wLegal_q, wLegal_d, wErr_q, wErr_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  awready_q, wready_q, bvalid_q;
    logic                  memWrEn;

    r_state_e              rState_q, rState_d;
    logic [ID_WIDTH-1:0]   rId_q, rId_d;
    logic [IDX_W-1:0]      rIdx_q, rIdx_d, rdIdx;
    logic [7:0]            rLen_q, rLen_d, rCnt_q, rCnt_d;
    logic                  rIncr_q, rIncr_d, rLegal_q, rLegal_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rdData;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d, arready_q, rvalid_q;
    logic                  arLegal;

    // Upper/lower address bits outside the word index are deliberately ignored.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{s_axi_awaddr, s_axi_araddr};

    axi_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk_i    (s_axi_aclk),
        .wrEn_i   (memWrEn),
        .wrIdx_i  (wIdx_q),
        .wrData_i (s_axi_wdata),
        .wrStrb_i (s_axi_wstrb),
        .rdIdx_i  (rdIdx),
        .rdData_o (rdData)
    );

    always_comb begin
        wState_d = wState_q;
        wId_d    = wId_q;
        wIdx_d   = wIdx_q;
        wLen_d   = wLen_q;
        wCnt_d   = wCnt_q;
        wIncr_d  = wIncr_q;
        wLegal_d = wLegal_q;
        wErr_d   = wErr_q;
        bresp_d  = bresp_q;
        memWrEn  = 1'b0;
        case (wState_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    wState_d = W_DATA;
                    wId_d    = s_axi_awid;
                    wIdx_d   = s_axi_awaddr[ADDR_LSB +: IDX_W];
                    wLen_d   = s_axi_awlen;
                    wCnt_d   = 8'd0;
                    wIncr_d  = (s_axi_awburst == BURST_INCR);
                    wLegal_d = burstLegal(s_axi_awsize, s_axi_awburst, FULL_SIZE);
                    wErr_d   = 1'b0;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && wready_q) begin
                    memWrEn = wLegal_q;
                    if (s_axi_wlast != (wCnt_q == wLen_q)) begin
                        wErr_d = 1'b1;
                    end
                    // The beat count, not wlast, decides where the burst ends.
                    if (wCnt_q == wLen_q) begin
                        wState_d = W_RESP;
                        bresp_d  = (!wLegal_q || wErr_d) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        wCnt_d = wCnt_q + 8'd1;
                        if (wIncr_q) begin
                            wIdx_d = wIdx_q + IDX_W'(1);
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready && bvalid_q) begin
                    wState_d = W_IDLE;
                end
            end
            default: wState_d = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wState_q  <= W_IDLE;
            wId_q     <= '0;
            wIdx_q    <= '0;
            wLen_q    <= '0;
            wCnt_q    <= '0;
            wIncr_q   <= 1'b0;
            wLegal_q  <= 1'b0;
            wErr_q    <= 1'b0;
            bresp_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            wState_q  <= wState_d;
            wId_q     <= wId_d;
            wIdx_q    <= wIdx_d;
            wLen_q    <= wLen_d;
            wCnt_q    <= wCnt_d;
            wIncr_q   <= wIncr_d;
            wLegal_q  <= wLegal_d;
            wErr_q    <= wErr_d;
            bresp_q   <= bresp_d;
            awready_q <= (wState_d == W_IDLE);
            wready_q  <= (wState_d == W_DATA);
            bvalid_q  <= (wState_d == W_RESP);
        end
    end

    // Array address for the beat that will be registered into rdata next.
    assign rdIdx   = (rState_q == R_IDLE) ? s_axi_araddr[ADDR_LSB +: IDX_W]
                   : (rIncr_q ? rIdx_q + IDX_W'(1) : rIdx_q);
    assign arLegal = burstLegal(s_axi_arsize, s_axi_arburst, FULL_SIZE);

    always_comb begin
        rState_d = rState_q;
        rId_d    = rId_q;
        rIdx_d   = rIdx_q;
        rLen_d   = rLen_q;
        rCnt_d   = rCnt_q;
        rIncr_d  = rIncr_q;
        rLegal_d = rLegal_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        case (rState_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    rState_d = R_DATA;
                    rId_d    = s_axi_arid;
                    rIdx_d   = rdIdx;
                    rLen_d   = s_axi_arlen;
                    rCnt_d   = 8'd0;
                    rIncr_d  = (s_axi_arburst == BURST_INCR);
                    rLegal_d = arLegal;
                    rdata_d  = arLegal ? rdData : '0;
                    rresp_d  = arLegal ? RESP_OKAY : RESP_SLVERR;
                    rlast_d  = (s_axi_arlen == 8'd0);
                end
            end
            R_DATA: begin
                if (s_axi_rready && rvalid_q) begin
                    if (rlast_q) begin
                        rState_d = R_IDLE;
                        rlast_d  = 1'b0;
                    end else begin
                        rIdx_d  = rdIdx;
                        rCnt_d  = rCnt_q + 8'd1;
                        rdata_d = rLegal_q ? rdData : '0;
                        rlast_d = ((rCnt_q + 8'd1) == rLen_q);
                    end
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rState_q  <= R_IDLE;
            rId_q     <= '0;
            rIdx_q    <= '0;
            rLen_q    <= '0;
            rCnt_q    <= '0;
            rIncr_q   <= 1'b0;
            rLegal_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            rState_q  <= rState_d;
            rId_q     <= rId_d;
            rIdx_q    <= rIdx_d;
            rLen_q    <= rLen_d;
            rCnt_q    <= rCnt_d;
            rIncr_q   <= rIncr_d;
            rLegal_q  <= rLegal_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            arready_q <= (rState_d == R_IDLE);
            rvalid_q  <= (rState_d == R_DATA);
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = wId_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rid     = rId_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_s_axi_mem.sv
// Directed bench for s_axi_mem: a word-level memory model predicts every R beat
// and B response, and a negedge monitor compares the DUT against it.
module tb_s_axi_mem;

    localparam int DEPTH = 1024;

    logic        clock = 1'b0;
    logic        aresetn = 1'b0;
    logic [0:0]  s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
    logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
    logic [2:0]  s_axi_awsize = '0, s_axi_arsize = '0;
    logic [1:0]  s_axi_awburst = '0, s_axi_arburst = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready = 1'b0;
    logic        s_axi_arvalid = 1'b0, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;

    always #5 clock = ~clock;

    s_axi_mem dut (
        .s_axi_aclk    (clock),
        .s_axi_aresetn (aresetn),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } rbeat_t;

    typedef struct {
        logic [1:0] resp;
        logic       id;
    } bexp_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model [DEPTH];
    rbeat_t      expR[$];
    bexp_t       expB[$];
    logic [31:0] gotR [256];
    int          rBeats = 0;
    int          bDone = 0;
    logic [1:0]  lastBresp = 2'b00;
    bit          monitorOn = 1'b1;
    logic [31:0] wDataTab [256];
    logic [3:0]  wStrbTab [256];

    task automatic checkOutput(input string name, input logic [31:0] actVal,
                               input logic [31:0] expVal);
        total++;
        if (actVal !== expVal) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actVal, expVal);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout/unexpected expected handshake", name);
    endtask

    // Every cycle a response channel is valid, its payload must match the
    // oldest predicted entry; it is retired only when the handshake happens.
    always @(negedge clock) begin
        if (aresetn && monitorOn) begin
            if (s_axi_rvalid) begin
                if (expR.size() == 0) begin
                    failNow("r_unexpected");
                end else begin
                    checkOutput("rdata", s_axi_rdata, expR[0].data);
                    checkOutput("rresp", {30'd0, s_axi_rresp}, {30'd0, expR[0].resp});
                    checkOutput("rlast", {31'd0, s_axi_rlast}, {31'd0, expR[0].last});
                    checkOutput("rid", {31'd0, s_axi_rid}, {31'd0, expR[0].id});
                    if (s_axi_rready) begin
                        gotR[rBeats % 256] = s_axi_rdata;
                        rBeats++;
                        void'(expR.pop_front());
                    end
                end
            end
            if (s_axi_bvalid) begin
                if (expB.size() == 0) begin
                    failNow("b_unexpected");
                end else begin
                    checkOutput("bresp", {30'd0, s_axi_bresp}, {30'd0, expB[0].resp});
                    checkOutput("bid", {31'd0, s_axi_bid}, {31'd0, expB[0].id});
                    if (s_axi_bready) begin
                        lastBresp = s_axi_bresp;
                        bDone++;
                        void'(expB.pop_front());
                    end
                end
            end
        end
    end

    task automatic waitReady(input string name, ref logic readySig);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!readySig && n < 200);
        if (!readySig) failNow(name);
        @(posedge clock);
        #1;
    endtask

    task automatic writeBurst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int wlastBeat);
        int    idx = int'(addr[11:2]);
        bit    legal = (size == 3'd2) && (burst <= 2'd1);
        bit    err = 1'b0;
        int    start = bDone;
        int    n = 0;
        bexp_t b;
        for (int i = 0; i <= int'(len); i++) begin
            if (legal) begin
                for (int k = 0; k < 4; k++) begin
                    if (wStrbTab[i][k]) model[idx][8*k +: 8] = wDataTab[i][8*k +: 8];
                end
            end
            if (burst == 2'd1) idx = (idx + 1) % DEPTH;
            if ((i == wlastBeat) != (i == int'(len))) err = 1'b1;
        end
        b.resp = (legal && !err) ? 2'b00 : 2'b10;
        b.id   = id;
        expB.push_back(b);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        waitReady("aw_handshake", s_axi_awready);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wDataTab[i];
            s_axi_wstrb  = wStrbTab[i];
            s_axi_wlast  = (i == wlastBeat);
            waitReady("w_handshake", s_axi_wready);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        s_axi_bready = 1'b1;
        while (bDone == start && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        s_axi_bready = 1'b0;
        if (bDone == start) begin
            failNow("b_timeout");
            expB.delete();
        end
    endtask

    task automatic readBurst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input bit toggle, output int base);
        int     idx = int'(addr[11:2]);
        bit     legal = (size == 3'd2) && (burst <= 2'd1);
        int     n = 0;
        rbeat_t r;
        base = rBeats;
        for (int i = 0; i <= int'(len); i++) begin
            r.data = legal ? model[idx] : 32'd0;
            r.resp = legal ? 2'b00 : 2'b10;
            r.last = (i == int'(len));
            r.id   = id;
            expR.push_back(r);
            if (burst == 2'd1) idx = (idx + 1) % DEPTH;
        end
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        waitReady("ar_handshake", s_axi_arready);
        s_axi_arvalid = 1'b0;
        while ((rBeats - base) <= int'(len) && n < 400) begin
            s_axi_rready = toggle ? (n % 2 == 0) : 1'b1;
            @(posedge clock);
            #1;
            n++;
        end
        s_axi_rready = 1'b0;
        if (expR.size() != 0) begin
            failNow("r_timeout");
            expR.delete();
        end
    endtask

    task automatic applyStimulus;
        int base;
        // INCR 16-beat write at an aliased high address, read back.
        for (int i = 0; i < 16; i++) begin
            wDataTab[i] = i;
            wStrbTab[i] = 4'hF;
        end
        writeBurst(1'b1, 32'h4000_0000, 8'd15, 3'd2, 2'b01, 15);
        checkOutput("t1_bresp", {30'd0, lastBresp}, 32'd0);
        readBurst(1'b0, 32'h4000_0000, 8'd15, 3'd2, 2'b01, 1'b0, base);
        for (int i = 0; i < 16; i++) checkOutput("t1_word", gotR[(base + i) % 256], i);

        // Byte strobes merge into an existing word.
        wDataTab[0] = 32'hAABB_CCDD; wStrbTab[0] = 4'hF;
        writeBurst(1'b0, 32'h0000_0010, 8'd0, 3'd2, 2'b01, 0);
        wDataTab[0] = 32'h1122_3344; wStrbTab[0] = 4'b0101;
        writeBurst(1'b0, 32'h0000_0010, 8'd0, 3'd2, 2'b01, 0);
        readBurst(1'b1, 32'h0000_0010, 8'd0, 3'd2, 2'b01, 1'b0, base);
        checkOutput("t2_strobe", gotR[base % 256], 32'hAA22_CC44);

        // FIXED burst keeps hitting word 8; word 9 keeps its earlier value.
        for (int i = 0; i < 4; i++) begin
            wDataTab[i] = i + 1;
            wStrbTab[i] = 4'hF;
        end
        writeBurst(1'b1, 32'h0000_0020, 8'd3, 3'd2, 2'b00, 3);
        readBurst(1'b0, 32'h0000_0020, 8'd1, 3'd2, 2'b01, 1'b0, base);
        checkOutput("t3_fixed_w8", gotR[base % 256], 32'd4);
        checkOutput("t3_fixed_w9", gotR[(base + 1) % 256], 32'd9);

        // INCR from word 1022 wraps through 1023 to 0 and 1.
        for (int i = 0; i < 4; i++) begin
            wDataTab[i] = 32'hA0 + i;
            wStrbTab[i] = 4'hF;
        end
        writeBurst(1'b0, 32'h0000_0FF8, 8'd3, 3'd2, 2'b01, 3);
        readBurst(1'b0, 32'h0000_0FF8, 8'd3, 3'd2, 2'b01, 1'b0, base);
        for (int i = 0; i < 4; i++) checkOutput("t4_wrap", gotR[(base + i) % 256], 32'hA0 + i);
        readBurst(1'b0, 32'h0000_0000, 8'd1, 3'd2, 2'b01, 1'b0, base);
        checkOutput("t4_word0", gotR[base % 256], 32'hA2);
        checkOutput("t4_word1", gotR[(base + 1) % 256], 32'hA3);

        // WRAP write and narrow read are rejected without touching memory.
        wDataTab[0] = 32'h5A5A_5A5A; wStrbTab[0] = 4'hF;
        writeBurst(1'b0, 32'h0000_0080, 8'd0, 3'd2, 2'b01, 0);
        wDataTab[0] = 32'hDEAD_BEEF;
        writeBurst(1'b1, 32'h0000_0080, 8'd0, 3'd2, 2'b10, 0);
        checkOutput("t5_bresp", {30'd0, lastBresp}, 32'd2);
        readBurst(1'b1, 32'h0000_0080, 8'd1, 3'd1, 2'b01, 1'b0, base);
        checkOutput("t5_narrow_data", gotR[base % 256], 32'd0);
        readBurst(1'b0, 32'h0000_0080, 8'd0, 3'd2, 2'b01, 1'b0, base);
        checkOutput("t5_unchanged", gotR[base % 256], 32'h5A5A_5A5A);

        // Stalled read beats stay put; early wlast yields SLVERR after 4 beats.
        readBurst(1'b1, 32'h0000_0028, 8'd3, 3'd2, 2'b01, 1'b1, base);
        for (int i = 0; i < 4; i++) checkOutput("t6_stall", gotR[(base + i) % 256], 32'd10 + i);
        for (int i = 0; i < 4; i++) wDataTab[i] = 32'h600 + i;
        writeBurst(1'b1, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 2);
        checkOutput("t6_early_wlast", {30'd0, lastBresp}, 32'd2);

        // Reset in the middle of a write and a stalled read.
        monitorOn = 1'b0;
        s_axi_awaddr = 32'h200; s_axi_awlen = 8'd7; s_axi_awsize = 3'd2;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        s_axi_araddr = 32'h0; s_axi_arlen = 8'd7; s_axi_arsize = 3'd2;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        waitReady("t7_aw", s_axi_awready);
        s_axi_awvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF;
        waitReady("t7_w", s_axi_wready);
        checkOutput("t7_rvalid_before", {31'd0, s_axi_rvalid}, 32'd1);
        aresetn = 1'b0;
        s_axi_wvalid = 1'b0;
        @(negedge clock);
        checkOutput("t7_reset_flags",
                    {26'd0, s_axi_awready, s_axi_wready, s_axi_bvalid,
                     s_axi_arready, s_axi_rvalid, s_axi_rlast}, 32'd0);
        @(posedge clock);
        #1 aresetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("t7_no_resp", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
        end
        @(posedge clock);
        #1 monitorOn = 1'b1;
        wDataTab[0] = 32'hCAFE_F00D; wStrbTab[0] = 4'hF;
        writeBurst(1'b0, 32'h0000_0084, 8'd0, 3'd2, 2'b01, 0);
        readBurst(1'b0, 32'h0000_0084, 8'd0, 3'd2, 2'b01, 1'b0, base);
        checkOutput("t7_recover", gotR[base % 256], 32'hCAFE_F00D);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_flags",
                    {26'd0, s_axi_awready, s_axi_wready, s_axi_bvalid,
                     s_axi_arready, s_axi_rvalid, s_axi_rlast}, 32'd0);
        checkOutput("reset_ids_resp", {26'd0, s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp}, 32'd0);
        checkOutput("reset_rdata", s_axi_rdata, 32'd0);
        @(posedge clock);
        #1 aresetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        applyStimulus();
        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s_axi_mem.md
Name: s_axi_mem

Overview:
AXI4 full slave memory that sits directly downstream of the team's burst master and consumes its write and read bursts.
- Backing store is a MEM_DEPTH x DATA_WIDTH register array.
- Independent write and read FSMs, one beat per cycle.
- Used as the burst target in system sims and as an on-chip scratch RAM.

Parameters:
ID_WIDTH, 1, width of AWID/ARID/BID/RID
DATA_WIDTH, 32, data bus width in bits; 32, 64 or 128
ADDR_WIDTH, 32, byte address width
MEM_DEPTH, 1024, number of DATA_WIDTH words; power of two

Ports:
s_axi_aclk  in  1  clock; all logic rising-edge
s_axi_aresetn  in  1  asynchronous active-low reset; release is synchronised externally
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write start byte address
s_axi_awlen  in  8  beats minus one
s_axi_awsize  in  3  beat size
s_axi_awburst  in  2  burst type
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  echoes latched awid
s_axi_bresp  out  2  OKAY=00 / SLVERR=10
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  ADDR_WIDTH  read start byte address
s_axi_arlen  in  8  beats minus one
s_axi_arsize  in  3  beat size
s_axi_arburst  in  2  burst type
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  echoes latched arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  OKAY / SLVERR
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset:
  - All ready/valid/last outputs are 0; bid, bresp, rid, rresp and rdata are 0.
  - Both FSMs go to IDLE. Memory contents are not reset.
  - Reset mid-burst abandons the burst; no response is issued afterwards.
- All outputs are registered.
- Word index = addr[ADDR_LSB +: log2(MEM_DEPTH)], with ADDR_LSB = log2(DATA_WIDTH/8).
  - Upper address bits are ignored, so the memory aliases modulo MEM_DEPTH.
  - Unaligned low bits are ignored.
  - The index wraps from MEM_DEPTH-1 to 0.
- Burst legality: a burst is legal when size == ADDR_LSB and burst is FIXED (00) or INCR (01).
  - FIXED: the index is held for every beat.
  - INCR: the index increments by 1 per beat.
  - WRAP or reserved type, or narrow size: the burst is illegal. It completes with full handshakes, makes no memory access, and responds SLVERR.
  - 4KB-crossing bursts are not checked; avoiding them is the master's responsibility.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. An AW handshake at cycle T latches id, index, len, burst and legality, and moves to W_DATA. awready=0 from T+1.
  - W_DATA: wready=1. Each W handshake writes the enabled bytes of wdata (per wstrb) when the burst is legal, and increments the beat counter.
  - The burst ends on the beat where the counter equals awlen, regardless of wlast. wready drops the next cycle.
  - A wlast value that disagrees with "counter == awlen" on any beat sets the error flag.
  - W_RESP: bvalid=1 with bresp = SLVERR if the burst was illegal or the error flag is set, else OKAY. bvalid holds until bready. bready already high gives a 1-cycle response.
  - W_RESP returns to W_IDLE, so awready=1 in the cycle after the B handshake.
- Read FSM, R_IDLE -> R_DATA:
  - AR handshake at T: arvalid && arready, with arready=1 in R_IDLE. rvalid=1 at T+1 with beat 0 in rdata.
  - Each R handshake loads the next beat the following cycle, giving 1 beat/cycle while rready is held.
  - rlast=1 exactly on beat arlen.
  - Illegal read burst: rdata=0 and rresp=SLVERR on every beat.
  - After the last R handshake the FSM goes to R_IDLE, and arready=1 the following cycle.
- rdata, rresp and rlast are stable while rvalid && !rready.
- Simultaneous write and read to the same word in the same cycle: the read returns the old data.
- No outstanding-transaction queueing: one write and one read in flight at a time, independently.
- awlen=0 is a single beat, and wlast must be 1 on it.

Decomposition:
- Package axi_pkg:
  - resp typedef (OKAY, EXOKAY, SLVERR, DECERR)
  - burst typedef (FIXED, INCR, WRAP)
  - Write-FSM and read-FSM state enums
- One sub-module, axi_mem_array: byte-enable write port plus read port, parameterised on DATA_WIDTH and MEM_DEPTH.

Test Plan:
- INCR write addr 0x40000000, len 15, data 0..15, full strobes, then read same range -> 16 beats 0..15, rlast only on beat 15, bresp and every rresp OKAY.
- Write one beat 0xAABBCCDD to word 4, then one beat 0x11223344 with wstrb 0101 -> read word 4 returns 0xAA22CC44.
- FIXED write len 3 to word 8 with data 1,2,3,4 -> word 8 reads 4; word 9 is unchanged.
- INCR len 3 starting at word MEM_DEPTH-2 -> writes words 1022, 1023, 0, 1 (wrap-around check).
- Write with awburst=10, then read with arsize=1 -> bresp=SLVERR, memory unchanged; every R beat rdata=0, rresp=SLVERR.
- Read with rready toggling 1-0-1 and wlast asserted early on beat 2 of a len 3 write -> R beats stable across the stall; the write completes after 4 beats with bresp SLVERR. Assert aresetn low mid-burst -> all valids/readys are 0 on the next edge.
